uart_rx_loader: RTL
===================

Name: uart_rx_loader

Overview:
Controller that sequences the UART byte receiver to load program words into instruction memory over the serial link. It supplies the receiver's clks_per_bit from a baud-select table and parses a framed byte stream: sync, word count, big-endian 16-bit words, then an XOR checksum. It writes each word to memory, holds the CPU during a load, and recovers the receiver, which otherwise latches in its error state, through a watchdog-driven receiver reset.

Parameters:
ADDR_WIDTH, 8, memory word-address width; max words per frame 2^ADDR_WIDTH-1 (count byte is 8 bits)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_W, 20, watchdog counter width
TIMEOUT_CYCLES, 500000, idle cycles between bytes before abort/recovery

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
baud_sel  in  2  0:9600 1:19200 2:115200 3:sim-fast
clks_per_bit  out  13  to receiver CLKS_PER_BIT
rx_done  in  1  receiver byte-valid pulse
rx_data  in  8  receiver data_bus
rx_rst  out  1  active-low reset to receiver
cpu_hold  out  1  1 = CPU held during load
mem_we  out  1  one-cycle write strobe
mem_addr  out  ADDR_WIDTH  word address
mem_wdata  out  16  word data
load_done  out  1  one-cycle pulse, frame accepted
load_error  out  1  one-cycle pulse, frame rejected or timed out

Behaviour:
- Reset (rst=0 at posedge):
  - State HUNT; addresses and counters zero.
  - clks_per_bit=5208; rx_rst=1; cpu_hold=0.
  - mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, load_error=0.
  - An active load is abandoned; no further writes are issued.
- Baud table (50 MHz): 0→5208, 1→2604, 2→434, 3→27.
  - clks_per_bit is registered and updates from baud_sel only while in HUNT.
  - A baud_sel change mid-frame is ignored until the frame returns to HUNT.
- FSM, advanced only on rx_done unless noted:
  - HUNT: rx_data==SYNC_BYTE → COUNT, set cpu_hold=1, mem_addr=0, chk=0. Any other byte is discarded.
  - COUNT: latch N=rx_data, chk=rx_data. N==0 → CHECK, else → HI.
  - HI: latch hi byte, chk^=byte → LO.
  - LO: chk^=byte. Next cycle: mem_we=1, mem_wdata={hi,lo}, mem_addr=current address.
    - The address increments the cycle after the write.
    - remaining-1==0 → CHECK, else → HI. No dead cycles.
  - CHECK: if byte==chk, pulse load_done and clear cpu_hold; else pulse load_error, cpu_hold stays 1. Either way → HUNT.
  - RECOVER: drive rx_rst=0 for exactly 2 cycles → HUNT.
- Pulse timing: load_done and load_error are registered and assert the cycle after the CHECK byte's rx_done.
- Watchdog:
  - Counter clears on every rx_done and on entry to HUNT or RECOVER; otherwise increments.
  - It reaching TIMEOUT_CYCLES-1 → RECOVER.
  - If the FSM was outside HUNT, load_error pulses in the same cycle; from HUNT no error pulse (silent receiver recovery).
- Simultaneous rx_done and watchdog expiry: rx_done wins and the counter clears.
- After an error, words already written stay in memory. cpu_hold remains 1 until a later frame passes CHECK.
- Width rules:
  - Checksum is an 8-bit XOR over the count byte and all data bytes.
  - Remaining count is 8 bits.
  - mem_addr wraps modulo 2^ADDR_WIDTH; no wrap is reachable with ADDR_WIDTH=8.

Decomposition:
- Shared package:
  - FSM state encodings (HUNT, COUNT, HI, LO, CHECK, RECOVER).
  - Baud constants 5208/2604/434/27.
  - SYNC_BYTE default.
  - RX_RST_CYCLES=2.
- One sub-module, rx_watchdog:
  - Inputs: clear, enable.
  - Output: expire pulse.
  - Parameters: TIMEOUT_W, TIMEOUT_CYCLES.

Test Plan:
- Good frame, baud_sel=3, TIMEOUT_CYCLES=2000; bytes A5 02 12 34 AB CD 42 → mem[0]=16'h1234, mem[1]=16'hABCD, exactly 2 mem_we pulses, load_done 1 cycle, cpu_hold high from the A5 until the cycle load_done asserts.
- Same frame with checksum 43 → both writes occur, load_error pulse, no load_done, cpu_hold stays 1; then the good frame → load_done, cpu_hold=0.
- Empty frame A5 00 00 → load_done, zero mem_we pulses.
- Noise 00 FF 5A, then a good frame → noise ignored, load result matches scenario 1.
- Truncated A5 02 12, then line idle → load_error exactly TIMEOUT_CYCLES-1 cycles after the last rx_done, rx_rst low 2 cycles, FSM in HUNT; a following good frame loads.
- baud_sel 3→0 between bytes 3 and 4 → clks_per_bit stays 27 until HUNT, then becomes 5208.
- rst low mid-frame after 1 word → all outputs at reset values, no further mem_we; a following good frame loads from address 0.

Source files
------------

// File: rtl/uart_rx_loader_pkg.sv
// rtl/uart_rx_loader_pkg.sv - shared states, baud table and framing constants for the serial loader
package uart_rx_loader_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_COUNT   = 3'd1,
        ST_HI      = 3'd2,
        ST_LO      = 3'd3,
        ST_CHECK   = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    localparam logic [12:0] CPB_9600   = 13'd5208;
    localparam logic [12:0] CPB_19200  = 13'd2604;
    localparam logic [12:0] CPB_115200 = 13'd434;
    localparam logic [12:0] CPB_SIM    = 13'd27;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         RX_RST_CYCLES     = 2;

    // Clock divisors assume a 50 MHz system clock.
    function automatic logic [12:0] baud_cpb(input logic [1:0] sel);
        case (sel)
            2'd0:    return CPB_9600;
            2'd1:    return CPB_19200;
            2'd2:    return CPB_115200;
            default: return CPB_SIM;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_loader_watchdog.sv
// rtl/uart_rx_loader_watchdog.sv - inter-byte idle watchdog for the serial loader
module rx_watchdog #(
    parameter int TIMEOUT_W      = 20,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TIMEOUT_W-1:0] LAST_BEFORE = TIMEOUT_W'(TIMEOUT_CYCLES - 2);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    // Fires on the edge at which the count reaches TIMEOUT_CYCLES-1.
    assign expire = enable && !clear && (count == LAST_BEFORE);

endmodule

// File: rtl/uart_rx_loader.sv
// rtl/uart_rx_loader.sv - parses framed serial bytes into instruction-memory word writes
import uart_rx_loader_pkg::*;

module uart_rx_loader #(
    parameter int         ADDR_WIDTH     = 8,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_W      = 20,
    parameter int         TIMEOUT_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            baud_sel,
    output logic [12:0]           clks_per_bit,
    input  logic                  rx_done,
    input  logic [7:0]            rx_data,
    output logic                  rx_rst,
    output logic                  cpu_hold,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  load_done,
    output logic                  load_error
);

    state_t                state, state_nx;
    logic [7:0]            remaining, chk, hi_byte;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            rst_cnt;
    logic                  expire, wd_clear, wd_enable;
    logic                  mem_we_nx, load_done_nx, load_error_nx, cpu_hold_nx;

    assign wd_clear  = rx_done || (state == ST_RECOVER);
    assign wd_enable = (state != ST_RECOVER);
    assign mem_addr  = addr;

    rx_watchdog #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nx;
        end
    end

    // A received byte always takes priority over a watchdog expiry.
    always_comb begin
        state_nx = state;
        if (state == ST_RECOVER) begin
            if (rst_cnt == 2'(RX_RST_CYCLES - 1)) state_nx = ST_HUNT;
        end else if (rx_done) begin
            case (state)
                ST_HUNT:  if (rx_data == SYNC_BYTE) state_nx = ST_COUNT;
                ST_COUNT: state_nx = (rx_data == 8'd0) ? ST_CHECK : ST_HI;
                ST_HI:    state_nx = ST_LO;
                ST_LO:    state_nx = (remaining == 8'd1) ? ST_CHECK : ST_HI;
                default:  state_nx = ST_HUNT;
            endcase
        end else if (expire) begin
            state_nx = ST_RECOVER;
        end
    end

    always_comb begin
        rx_rst        = (state != ST_RECOVER);
        mem_we_nx     = rx_done && (state == ST_LO);
        load_done_nx  = rx_done && (state == ST_CHECK) && (rx_data == chk);
        load_error_nx = (rx_done && (state == ST_CHECK) && (rx_data != chk))
                     || (expire && (state != ST_HUNT));
        cpu_hold_nx   = cpu_hold;
        if (rx_done && (state == ST_HUNT) && (rx_data == SYNC_BYTE)) cpu_hold_nx = 1'b1;
        if (load_done_nx) cpu_hold_nx = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            clks_per_bit <= CPB_9600;
            cpu_hold     <= 1'b0;
            mem_we       <= 1'b0;
            mem_wdata    <= 16'd0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
            addr         <= '0;
            remaining    <= 8'd0;
            chk          <= 8'd0;
            hi_byte      <= 8'd0;
            rst_cnt      <= 2'd0;
        end else begin
            mem_we     <= mem_we_nx;
            load_done  <= load_done_nx;
            load_error <= load_error_nx;
            cpu_hold   <= cpu_hold_nx;
            rst_cnt    <= (state == ST_RECOVER) ? rst_cnt + 2'd1 : 2'd0;
            if (state == ST_HUNT) clks_per_bit <= baud_cpb(baud_sel);
            if (mem_we) addr <= addr + ADDR_WIDTH'(1);
            if (rx_done) begin
                case (state)
                    ST_HUNT: if (rx_data == SYNC_BYTE) begin
                        addr <= '0;
                        chk  <= 8'd0;
                    end
                    ST_COUNT: begin
                        remaining <= rx_data;
                        chk       <= rx_data;
                    end
                    ST_HI: begin
                        hi_byte <= rx_data;
                        chk     <= chk ^ rx_data;
                    end
                    ST_LO: begin
                        chk       <= chk ^ rx_data;
                        mem_wdata <= {hi_byte, rx_data};
                        remaining <= remaining - 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
